uart_out_mux_pkt: RTL
=====================

Name: uart_out_mux_pkt

Overview:
Next-generation USB->UART demultiplexer. It reads length-framed packets from the USB RX FIFO (first-word-fall-through) and delivers each payload byte to the addressed UART transmitter. It honours per-channel tx_ready backpressure, supports a broadcast address, and discards frames whose address is invalid. It sits between the USB RX FIFO and a bank of UART_COUNT transmitters.

Parameters:
DATA_BITS, 8, width of FIFO bytes and UART data.
UART_COUNT, 4, number of UART channels; legal range 1..254.
COUNTER_BITS, 16, width of the dropped-frame counter.
BROADCAST_EN, 1, 1 = channel index 8'hFF addresses all channels; 0 = 8'hFF is treated as invalid.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
fifo_empty  in  1  FIFO empty flag
fifo_read  out  1  registered one-cycle pop pulse
fifo_data  in  DATA_BITS  FWFT head byte; valid while fifo_empty=0
tx_ready  in  UART_COUNT  per-channel transmitter can accept a byte
write  out  UART_COUNT  registered one-cycle write strobe per channel
data  out  UART_COUNT*DATA_BITS  per-channel data; slice i = data[i*DATA_BITS +: DATA_BITS]
busy  out  1  high whenever state != IDLE
drop_count  out  COUNTER_BITS  saturating count of frames discarded for invalid index

Behaviour:
- Reset is asynchronous and active-high; all registers clear immediately. While reset is high, outputs are: fifo_read=0, write=0, data=0, busy=0, drop_count=0, state=IDLE.
- Reset mid-frame abandons the frame. No partial write is issued after reset. Resynchronising the FIFO is the upstream's responsibility.
- Frame format: byte0 = channel index, byte1 = length N (0..255), then N payload bytes. N=0 means the frame is header only.
- Byte consumption rule: a byte is accepted on the edge where the state requires it and fifo_empty=0. On that edge fifo_read_reg is set to 1, producing a single pulse. The FSM then spends exactly one cycle in a GAP state so the FIFO head can update. No byte is sampled during GAP.
- Target classification (latched at header acceptance):
  - index < UART_COUNT: UNICAST.
  - index == 8'hFF and BROADCAST_EN=1: BCAST.
  - otherwise: DROP. drop_count is incremented when the header is accepted and saturates at all-ones.
- States and transitions:
  - IDLE: when ~fifo_empty, latch index, classify, pop -> HDR_GAP.
  - HDR_GAP -> LEN.
  - LEN: when ~fifo_empty, latch N into an 8-bit remaining counter, pop -> LEN_GAP.
  - LEN_GAP -> IDLE if N==0, else DATA.
  - DATA: accept a byte when ~fifo_empty AND the target is ready. Target ready means tx_ready[idx] for UNICAST, &tx_ready for BCAST, and always true for DROP.
  - On accept: pop; decrement remaining; for UNICAST, set data slice idx = fifo_data and write[idx]=1 on the same edge; for BCAST, set every slice and write every bit; for DROP, no write. Then -> DATA_GAP.
  - DATA_GAP -> IDLE if remaining==0, else DATA.
- Latency: write and the data slice become valid 1 cycle after the accepting edge, in the same cycle fifo_read is high.
  - Sustained throughput is 1 byte per 2 cycles.
  - tx_ready is next sampled 2 edges after acceptance. The UART must therefore drop tx_ready within 1 cycle of seeing write.
- Data slices not written in a cycle hold their previous value. write is 0 in every cycle other than the strobe cycle.
- Backpressure: in DATA, if the target is not ready, no pop and no write occur; the FSM waits indefinitely.
  - For BCAST, the byte waits until all channels are ready simultaneously.
  - fifo_empty in any consuming state is simply a wait.
- busy=1 from the edge leaving IDLE until the edge returning to IDLE.

Test Plan:
1. Reset, then FIFO {02,03,41,42,43} with UART_COUNT=4 and all tx_ready=1 -> write[2] pulses 3 times, 2 cycles apart, with slice2 = 41,42,43. fifo_read pulses 5 times; other slices stay 0; busy returns to 0; drop_count=0.
2. FIFO {01,02,55,66}, hold tx_ready[1]=0 for 10 cycles after LEN_GAP -> no fifo_read and no write during the hold. Release -> write[1] with 55, then 66.
3. FIFO {FF,01,A5} with tx_ready=4'b1011 for 5 cycles, then 4'b1111 -> a single cycle with write=4'b1111 and all slices = A5. Repeat with BROADCAST_EN=0 -> no write, drop_count=1.
4. FIFO {07,02,11,22,00,00} -> payload consumed without any write, drop_count=1. The header-only frame {00,00} ends in IDLE with no write. Preload drop_count near its maximum -> it saturates at all-ones.
5. Assert reset asynchronously, mid-cycle, during DATA of frame {00,04,...} -> all outputs clear immediately, with no pending write pulse. After release, a new frame {03,01,99} produces write[3] with 99.
6. Apply fifo_empty=1 between every byte of frame {00,02,10,20} -> the FSM waits in LEN/DATA and produces writes 10, 20 with no spurious pops.

Source files
------------

// File: rtl/uart_out_mux_pkt.sv
// Routes length-framed packets from a FWFT FIFO to UART_COUNT transmitters: byte0 = channel, byte1 = length, then payload.
// Each pop/write is a registered pulse one cycle after the accepting edge (1 byte / 2 cycles); stalls on fifo_empty or target tx_ready.
module uart_out_mux_pkt #(
  parameter int DATA_BITS    = 8,
  parameter int UART_COUNT   = 4,
  parameter int COUNTER_BITS = 16,
  parameter bit BROADCAST_EN = 1'b1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            fifo_empty,
  output logic                            fifo_read,
  input  logic [DATA_BITS-1:0]            fifo_data,
  input  logic [UART_COUNT-1:0]           tx_ready,
  output logic [UART_COUNT-1:0]           write,
  output logic [UART_COUNT*DATA_BITS-1:0] data,
  output logic                            busy,
  output logic [COUNTER_BITS-1:0]         drop_count
);

  typedef enum logic [2:0] {S_IDLE, S_HDR_GAP, S_LEN, S_LEN_GAP, S_DATA, S_DATA_GAP} state_t;
  typedef enum logic [1:0] {T_UNICAST, T_BCAST, T_DROP} tgt_t;

  state_t     state, state_nxt;
  tgt_t       tgt, hdr_tgt;
  logic [7:0] idx, remaining, head;
  logic       uni_rdy, tgt_rdy, accept;

  // Channel index and length are 8-bit header fields regardless of DATA_BITS.
  assign head = fifo_data[7:0];

  always_comb begin
    hdr_tgt = T_DROP;
    if (int'(head) < UART_COUNT)
      hdr_tgt = T_UNICAST;
    else if (BROADCAST_EN && head == 8'hFF)
      hdr_tgt = T_BCAST;
  end

  always_comb begin
    uni_rdy = 1'b0;
    for (int i = 0; i < UART_COUNT; i++)
      if (int'(idx) == i) uni_rdy = tx_ready[i];
  end

  always_comb begin
    case (tgt)
      T_UNICAST: tgt_rdy = uni_rdy;
      T_BCAST:   tgt_rdy = &tx_ready;
      default:   tgt_rdy = 1'b1;
    endcase
  end

  assign accept = ~fifo_empty &
                  ((state == S_IDLE) | (state == S_LEN) | ((state == S_DATA) & tgt_rdy));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (accept) state_nxt = S_HDR_GAP;
      S_HDR_GAP:  state_nxt = S_LEN;
      S_LEN:      if (accept) state_nxt = S_LEN_GAP;
      S_LEN_GAP:  state_nxt = (remaining == 8'd0) ? S_IDLE : S_DATA;
      S_DATA:     if (accept) state_nxt = S_DATA_GAP;
      S_DATA_GAP: state_nxt = (remaining == 8'd0) ? S_IDLE : S_DATA;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // State-decoded output
  always_comb begin
    busy = (state != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_read  <= 1'b0;
      write      <= '0;
      data       <= '0;
      drop_count <= '0;
      idx        <= '0;
      remaining  <= '0;
      tgt        <= T_DROP;
    end else begin
      fifo_read <= accept;
      write     <= '0;
      if (accept) begin
        case (state)
          S_IDLE: begin
            idx <= head;
            tgt <= hdr_tgt;
            if (hdr_tgt == T_DROP && drop_count != '1)
              drop_count <= drop_count + 1'b1;
          end
          S_LEN:  remaining <= head;
          S_DATA: begin
            remaining <= remaining - 8'd1;
            for (int i = 0; i < UART_COUNT; i++) begin
              if (tgt == T_BCAST || (tgt == T_UNICAST && int'(idx) == i)) begin
                write[i]                         <= 1'b1;
                data[i*DATA_BITS +: DATA_BITS]   <= fifo_data;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
